// File: rtl/dnn_accel_pio_pkg.sv
// Shared constants for the accelerator's Avalon-MM parallel I/O ports:
// register addresses, edge-select encodings and bus width.
package dnn_accel_pio_pkg;

  localparam int RDATA_W = 32;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/dnn_accel_system_sw_in_if.sv
// Avalon-MM slave register bus of the switch/button input port.
interface dnn_accel_system_sw_in_if;
  import dnn_accel_pio_pkg::*;

  // A cycle with chipselect high is one transfer with no wait states:
  // write_n low writes at that edge; write_n high is a read and readdata
  // carries the register one edge later, then holds until the next read.
  logic [1:0]         address;
  logic               chipselect;
  logic               write_n;
  logic [RDATA_W-1:0] writedata;
  logic [RDATA_W-1:0] readdata;

  modport master (output address, chipselect, write_n, writedata,
                  input  readdata);
  modport slave  (input  address, chipselect, write_n, writedata,
                  output readdata);

endinterface

// File: rtl/dnn_accel_sync_edge.sv
// Per-bit synchroniser for asynchronous pins plus one-cycle-delayed copy
// and the selected edge detector (rising, falling or any).
module dnn_accel_sync_edge
  import dnn_accel_pio_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] edge_pulse
);

  logic [WIDTH-1:0] stages [SYNC_STAGES];
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) stages[i] <= '0;
      prev <= '0;
    end else begin
      stages[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) stages[i] <= stages[i-1];
      prev <= stages[SYNC_STAGES-1];
    end
  end

  assign sync = stages[SYNC_STAGES-1];

  always_comb begin
    edge_pulse = '0;
    case (EDGE_TYPE)
      EDGE_RISING:  edge_pulse = sync & ~prev;
      EDGE_FALLING: edge_pulse = ~sync & prev;
      default:      edge_pulse = sync ^ prev;
    endcase
  end

endmodule

// File: rtl/dnn_accel_system_sw_in.sv
// Switch/button input port: synchronised level register, W1C edge capture,
// interrupt mask and a registered level interrupt.
module dnn_accel_system_sw_in
  import dnn_accel_pio_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  dnn_accel_system_sw_in_if.slave        bus,
  input  logic [WIDTH-1:0]               in_port,
  output logic                           irq
);

  localparam int                CNT_W       = 3;
  localparam logic [CNT_W-1:0]  SETTLE_INIT = CNT_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0]   sync;
  logic [WIDTH-1:0]   edge_pulse;
  logic [WIDTH-1:0]   edge_set;
  logic [WIDTH-1:0]   edge_clr;
  logic [WIDTH-1:0]   edge_capture;
  logic [WIDTH-1:0]   irq_mask;
  logic [WIDTH-1:0]   wr_val;
  logic [CNT_W-1:0]   settle_cnt;
  logic               rd_en;
  logic               wr_en;
  logic [RDATA_W-1:0] rd_mux;
  logic               unused_wd;

  dnn_accel_sync_edge #(
    .WIDTH       (WIDTH),
    .EDGE_TYPE   (EDGE_TYPE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk        (clk),
    .reset      (reset),
    .in_port    (in_port),
    .sync       (sync),
    .edge_pulse (edge_pulse)
  );

  assign rd_en     = bus.chipselect & bus.write_n;
  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign wr_val    = bus.writedata[WIDTH-1:0];
  assign unused_wd = &{1'b0, bus.writedata};

  // Pins already high when reset releases must not look like edges while
  // the synchroniser and prev register are still filling.
  assign edge_set = (settle_cnt == '0) ? edge_pulse : '0;
  assign edge_clr = (wr_en && bus.address == ADDR_EDGE) ? wr_val : '0;

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = sync;
      ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_capture;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      settle_cnt   <= SETTLE_INIT;
      edge_capture <= '0;
      irq_mask     <= '0;
      irq          <= 1'b0;
      bus.readdata <= '0;
    end else begin
      if (settle_cnt != '0) settle_cnt <= settle_cnt - CNT_W'(1);
      // A new edge beats a simultaneous W1C of the same bit.
      edge_capture <= (edge_capture & ~edge_clr) | edge_set;
      if (wr_en && bus.address == ADDR_MASK) irq_mask <= wr_val;
      irq <= |(edge_capture & irq_mask);
      if (rd_en) bus.readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_dnn_accel_system_sw_in.sv
// Bench for the switch input port: rising-edge and any-edge instances share
// pins and bus stimulus and are compared each cycle against a history model.
module tb_dnn_accel_system_sw_in;
  import dnn_accel_pio_pkg::*;

  localparam int W = 10;
  localparam int S = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [W-1:0] in_port;
  logic         irq0, irq1;
  logic [1:0]   addr;
  logic         cs, wn;
  logic [31:0]  wd;

  dnn_accel_system_sw_in_if bus0 ();
  dnn_accel_system_sw_in_if bus1 ();

  assign bus0.address = addr;  assign bus1.address = addr;
  assign bus0.chipselect = cs; assign bus1.chipselect = cs;
  assign bus0.write_n = wn;    assign bus1.write_n = wn;
  assign bus0.writedata = wd;  assign bus1.writedata = wd;

  dnn_accel_system_sw_in #(.WIDTH(W), .EDGE_TYPE(0), .SYNC_STAGES(S)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave), .in_port(in_port), .irq(irq0));
  dnn_accel_system_sw_in #(.WIDTH(W), .EDGE_TYPE(2), .SYNC_STAGES(S)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave), .in_port(in_port), .irq(irq1));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hist[0] is the newest pin sample taken since reset; the synchronised
  // level is the sample S-1 edges old, the previous level one older.
  logic [W-1:0] hist [8];
  int           nsamp;
  int           etype [2] = '{0, 2};
  logic [W-1:0] cap_m [2];
  logic [W-1:0] mask_m [2];
  logic         irq_m [2];
  logic [31:0]  rd_m [2];
  bit           model_on = 1'b0;

  function automatic logic [W-1:0] edge_rule(input int t, input logic [W-1:0] cur, input logic [W-1:0] prv);
    if (t == 0) return cur & ~prv;
    if (t == 1) return ~cur & prv;
    return cur ^ prv;
  endfunction

  always @(posedge clk) begin : model_blk
    logic [W-1:0] sync_now, ev, clr;
    if (reset) begin
      model_on = 1'b1;
      nsamp = 0;
      for (int k = 0; k < 8; k++) hist[k] = '0;
      for (int i = 0; i < 2; i++) begin
        cap_m[i] = '0; mask_m[i] = '0; irq_m[i] = 1'b0; rd_m[i] = '0;
      end
    end else begin
      sync_now = (nsamp >= S) ? hist[S-1] : '0;
      clr = (cs && !wn && addr == 2'd3) ? wd[W-1:0] : '0;
      for (int i = 0; i < 2; i++) begin
        ev = (nsamp >= S + 1) ? edge_rule(etype[i], hist[S-1], hist[S]) : '0;
        irq_m[i] = |(cap_m[i] & mask_m[i]);
        if (cs && wn) begin
          case (addr)
            2'd0: rd_m[i] = 32'(sync_now);
            2'd2: rd_m[i] = 32'(mask_m[i]);
            2'd3: rd_m[i] = 32'(cap_m[i]);
            default: rd_m[i] = 32'd0;
          endcase
        end
        cap_m[i] = (cap_m[i] & ~clr) | ev;
        if (cs && !wn && addr == 2'd2) mask_m[i] = wd[W-1:0];
      end
      for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = in_port;
      if (nsamp < 8) nsamp++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_on) begin
      check("rd_rise", bus0.readdata, rd_m[0]);
      check("irq_rise", 32'(irq0), 32'(irq_m[0]));
      check("rd_any", bus1.readdata, rd_m[1]);
      check("irq_any", 32'(irq1), 32'(irq_m[1]));
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic bus_idle();
    cs = 1'b0; wn = 1'b1; addr = 2'd0; wd = '0;
  endtask

  task automatic do_read(input logic [1:0] a, output logic [31:0] r0, output logic [31:0] r1);
    cs = 1'b1; wn = 1'b1; addr = a;
    @(negedge clk);
    r0 = bus0.readdata; r1 = bus1.readdata;
    bus_idle();
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; wn = 1'b0; addr = a; wd = d;
    @(negedge clk);
    bus_idle();
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] r0, r1;
  int          sel;

  initial begin
    bus_idle();
    reset = 1'b1;
    in_port = 10'h3FF;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Pins high through reset release: no spurious capture.
    repeat (10) @(negedge clk);
    do_read(2'd3, r0, r1);
    check("settle_cap_rise", r0, 32'h0);
    check("settle_cap_any", r1, 32'h0);
    check("settle_irq", 32'(irq0), 32'h0);
    do_read(2'd0, r0, r1);
    check("data_3ff", r0, 32'h3FF);

    // Rising bit0: capture after 3 edges, irq after 4.
    in_port = '0;
    repeat (6) @(negedge clk);
    do_write(2'd3, 32'h3FF);
    do_write(2'd2, 32'h1);
    in_port = 10'h001;
    repeat (3) @(negedge clk);
    check("irq_c3_low", 32'(irq0), 32'h0);
    @(negedge clk);
    check("irq_c4_high", 32'(irq0), 32'h1);
    check("irq_any_c4_high", 32'(irq1), 32'h1);
    do_read(2'd3, r0, r1);
    check("cap_bit0", r0, 32'h1);
    in_port = '0;
    repeat (5) @(negedge clk);
    do_read(2'd3, r0, r1);
    check("fall_ignored", r0, 32'h1);

    // W1C: zero has no effect, one clears; irq follows a cycle later.
    do_write(2'd3, 32'h0);
    do_read(2'd3, r0, r1);
    check("w1c_zero", r0, 32'h1);
    cs = 1'b1; wn = 1'b0; addr = 2'd3; wd = 32'h1;
    @(negedge clk);
    bus_idle();
    check("irq_clear_lag", 32'(irq0), 32'h1);
    @(negedge clk);
    check("irq_cleared", 32'(irq0), 32'h0);
    do_read(2'd3, r0, r1);
    check("cap_cleared", r0, 32'h0);

    // Same-cycle set and W1C on bit2: set wins.
    do_write(2'd2, 32'h4);
    in_port = 10'h004;
    @(negedge clk);
    in_port = '0;
    repeat (5) @(negedge clk);
    check("irq_bit2", 32'(irq0), 32'h1);
    in_port = 10'h004;
    repeat (2) @(negedge clk);
    cs = 1'b1; wn = 1'b0; addr = 2'd3; wd = 32'h4;
    @(negedge clk);
    bus_idle();
    repeat (2) @(negedge clk);
    check("irq_set_wins", 32'(irq0), 32'h1);
    do_read(2'd3, r0, r1);
    check("cap_set_wins", r0, 32'h4);

    // Mask width, reserved address, read latency and hold.
    do_write(2'd2, 32'hFFFF_FFFF);
    do_read(2'd1, r0, r1);
    check("rsvd_zero", r0, 32'h0);
    do_read(2'd2, r0, r1);
    check("mask_3ff", r0, 32'h3FF);
    repeat (3) @(negedge clk);
    check("rd_hold", bus0.readdata, 32'h3FF);

    // One-cycle pulse on bit5 (bit2 drops at the same time).
    in_port = 10'h020;
    @(negedge clk);
    in_port = '0;
    repeat (5) @(negedge clk);
    do_read(2'd3, r0, r1);
    check("pulse_rise", r0, 32'h24);
    check("pulse_any", r1, 32'h24);

    // Reset with captures pending.
    reset = 1'b1;
    @(negedge clk);
    check("rst_irq_rise", 32'(irq0), 32'h0);
    check("rst_irq_any", 32'(irq1), 32'h0);
    reset = 1'b0;
    do_read(2'd2, r0, r1);
    check("rst_mask", r0, 32'h0);
    do_read(2'd3, r0, r1);
    check("rst_cap", r1, 32'h0);

    // Randomised traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) in_port = W'($urandom);
        else in_port = in_port ^ (W'(1) << $urandom_range(0, W - 1));
      end
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        bus_idle();
      end else if (sel < 7) begin
        cs = 1'b1; wn = 1'b1; addr = 2'($urandom_range(0, 3)); wd = $urandom;
      end else begin
        cs = 1'b1; wn = 1'b0; addr = 2'($urandom_range(0, 3)); wd = $urandom;
      end
      reset = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    bus_idle();
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
